// File: rtl/timer_counter.sv
// 8051-style timer/counter: TL/TH pair, overflow flags, four count modes.
// Define TIMER_SPLIT_MODE_EN to enable mode 11 split operation.
module timer_counter #(
  parameter int BYTE_W  = 8,
  parameter int PRESC_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_wr_tl,
  input  logic              i_wr_th,
  input  logic [1:0]        i_mode,
  input  logic              i_ct,
  input  logic              i_gate,
  input  logic              i_int_n,
  input  logic              i_t_pin,
  input  logic              i_tr,
  input  logic              i_tr_h,
  input  logic              i_tf_clr,
  input  logic              i_tfh_clr,
  output logic [BYTE_W-1:0] o_tl,
  output logic [BYTE_W-1:0] o_th,
  output logic              o_tf,
  output logic              o_tf_h
);

  localparam int W2 = 2 * BYTE_W;
  localparam logic [BYTE_W-1:0] ONES = '1;
  localparam logic [BYTE_W-1:0] MASK =
    ONES >> (BYTE_W - PRESC_W);

  logic [BYTE_W-1:0] tl, th;
  logic [BYTE_W-1:0] tl_nx, th_nx;
  logic [W2-1:0]     cnt_inc;
  logic              tf, tf_h, pin_q;
  logic              tf_set, tfh_set, tfh_clr;
  logic              run, pin_edge, ev;

`ifdef TIMER_SPLIT_MODE_EN
  logic ev_h;
  assign ev_h    = i_tick & i_tr_h;
  assign tfh_clr = i_tfh_clr;
`else
  logic unused_split;
  assign unused_split = i_tr_h ^ i_tfh_clr;
  assign tfh_clr      = 1'b0;
`endif

  assign run      = i_tr & (~i_gate | i_int_n);
  assign pin_edge = pin_q & ~i_t_pin;
  assign ev       = i_tick & run & (~i_ct | pin_edge);
  assign cnt_inc  = {th, tl} + W2'(1);

  always_comb begin
    tl_nx   = tl;
    th_nx   = th;
    tf_set  = 1'b0;
    tfh_set = 1'b0;
    unique case (i_mode)
      2'b00: begin
        if (ev) begin
          tl_nx = (tl & ~MASK) | ((tl + BYTE_W'(1)) & MASK);
          if ((tl & MASK) == MASK) begin
            th_nx  = th + BYTE_W'(1);
            tf_set = (th == ONES) & ~i_wr_th;
          end
        end
      end
      2'b01: begin
        // a write to either half freezes the whole 16-bit count
        if (ev & ~i_wr_tl & ~i_wr_th) begin
          {th_nx, tl_nx} = cnt_inc;
          tf_set         = &{th, tl};
        end
      end
      2'b10: begin
        if (ev) begin
          if (tl == ONES) begin
            tl_nx  = th;
            tf_set = ~i_wr_tl;
          end else begin
            tl_nx = tl + BYTE_W'(1);
          end
        end
      end
      default: begin
`ifdef TIMER_SPLIT_MODE_EN
        if (ev) begin
          tl_nx  = tl + BYTE_W'(1);
          tf_set = (tl == ONES) & ~i_wr_tl;
        end
        if (ev_h) begin
          th_nx   = th + BYTE_W'(1);
          tfh_set = (th == ONES) & ~i_wr_th;
        end
`endif
      end
    endcase
    if (i_wr_tl) tl_nx = i_byte;
    if (i_wr_th) th_nx = i_byte;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tl    <= '0;
      th    <= '0;
      tf    <= 1'b0;
      tf_h  <= 1'b0;
      pin_q <= 1'b1;
    end else begin
      tl <= tl_nx;
      th <= th_nx;
      if (i_tick) pin_q <= i_t_pin;
      if (tf_set) tf <= 1'b1;
      else if (i_tf_clr) tf <= 1'b0;
      if (tfh_set) tf_h <= 1'b1;
      else if (tfh_clr) tf_h <= 1'b0;
    end
  end

  assign o_tl   = tl;
  assign o_th   = th;
  assign o_tf   = tf;
  assign o_tf_h = tf_h;

endmodule

// File: tb/tb_timer_counter.sv
// Directed vector bench for timer_counter (8-bit bytes, 5-bit prescale).
// Split-mode expectations follow TIMER_SPLIT_MODE_EN.
module tb_timer_counter;

  typedef struct {
    logic       rst_n, tick, wtl, wth;
    logic [7:0] dat;
    logic [1:0] mode;
    logic       ct, gate, int_n, pin, tr, tr_h, tfc, tfhc;
    logic [7:0] e_tl, e_th;
    logic       e_tf, e_tfh;
  } vec_t;

`ifdef TIMER_SPLIT_MODE_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, tick, wtl, wth;
  logic [7:0] dat;
  logic [1:0] mode;
  logic       ct, gate, int_n, pin, tr, tr_h, tfc, tfhc;
  logic [7:0] tl, th;
  logic       tf, tf_h;

  int nvec = 0;
  int nbad = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  timer_counter #(.BYTE_W(8), .PRESC_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick),
    .i_byte(dat), .i_wr_tl(wtl), .i_wr_th(wth),
    .i_mode(mode), .i_ct(ct), .i_gate(gate),
    .i_int_n(int_n), .i_t_pin(pin), .i_tr(tr),
    .i_tr_h(tr_h), .i_tf_clr(tfc), .i_tfh_clr(tfhc),
    .o_tl(tl), .o_th(th), .o_tf(tf), .o_tf_h(tf_h)
  );

  function automatic vec_t v(
    input logic r, k, a, b, input logic [7:0] d,
    input logic [1:0] m, input logic c, g, n, p,
    input logic t, h, fc, hc, input logic [7:0] etl,
    input logic [7:0] eth, input logic etf, etfh);
    vec_t x;
    x = '{r, k, a, b, d, m, c, g, n, p, t, h, fc, hc,
          etl, eth, etf, etfh};
    return x;
  endfunction

  task automatic apply(input vec_t x, input string nm,
                       input bit chk);
    rst_n = x.rst_n; tick = x.tick; wtl = x.wtl;
    wth = x.wth; dat = x.dat; mode = x.mode; ct = x.ct;
    gate = x.gate; int_n = x.int_n; pin = x.pin;
    tr = x.tr; tr_h = x.tr_h; tfc = x.tfc; tfhc = x.tfhc;
    @(posedge clk);
    #1;
    if (chk) begin
      nvec++;
      if (tl !== x.e_tl || th !== x.e_th ||
          tf !== x.e_tf || tf_h !== x.e_tfh) begin
        nbad++;
        $display("FAIL %s: got tl=%h th=%h tf=%b tfh=%b want tl=%h th=%h tf=%b tfh=%b",
                 nm, tl, th, tf, tf_h,
                 x.e_tl, x.e_th, x.e_tf, x.e_tfh);
      end
    end
  endtask

  initial begin
    // r k wl wh dat mode ct g n p tr th fc hc | tl th tf tfh
    vq.push_back(v(0,0,0,0,8'h00,1,0,0,1,1,0,0,0,0, 8'h00,8'h00,0,0));
    vq.push_back(v(1,0,1,0,8'hFE,1,0,0,1,1,0,0,0,0, 8'hFE,8'h00,0,0));
    vq.push_back(v(1,0,0,1,8'hFF,1,0,0,1,1,0,0,0,0, 8'hFE,8'hFF,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,0,0,1,1,1,0,0,0, 8'hFF,8'hFF,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,0,0,1,1,1,0,0,0, 8'h00,8'h00,1,0));
    vq.push_back(v(1,1,0,0,8'h00,1,0,0,1,1,1,0,0,0, 8'h01,8'h00,1,0));
    vq.push_back(v(1,0,0,0,8'h00,1,0,0,1,1,1,0,0,0, 8'h01,8'h00,1,0));
    vq.push_back(v(1,0,0,0,8'h00,1,0,0,1,1,1,0,1,0, 8'h01,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,0,1,0,1,1,0,0,0, 8'h01,8'h00,0,0));
    vq.push_back(v(1,0,1,0,8'hFF,0,0,0,1,1,0,0,0,0, 8'hFF,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,0,0,0,1,1,1,0,0,0, 8'hE0,8'h01,0,0));
    vq.push_back(v(1,0,1,0,8'h1F,0,0,0,1,1,0,0,0,0, 8'h1F,8'h01,0,0));
    vq.push_back(v(1,0,0,1,8'hFF,0,0,0,1,1,0,0,0,0, 8'h1F,8'hFF,0,0));
    vq.push_back(v(1,1,0,0,8'h00,0,0,0,1,1,1,0,0,0, 8'h00,8'h00,1,0));
    vq.push_back(v(1,0,0,0,8'h00,0,0,0,1,1,0,0,1,0, 8'h00,8'h00,0,0));
    vq.push_back(v(1,0,0,1,8'h9C,2,0,0,1,1,0,0,0,0, 8'h00,8'h9C,0,0));
    vq.push_back(v(1,0,1,0,8'hFF,2,0,0,1,1,0,0,0,0, 8'hFF,8'h9C,0,0));
    vq.push_back(v(1,1,0,0,8'h00,2,0,0,1,1,1,0,0,0, 8'h9C,8'h9C,1,0));
    vq.push_back(v(1,0,0,0,8'h00,2,0,0,1,1,0,0,1,0, 8'h9C,8'h9C,0,0));
    // counter mode, gated, int_n high: three falling edges
    vq.push_back(v(1,0,1,1,8'h00,1,1,1,1,1,0,0,0,0, 8'h00,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,0,1,0,0,0, 8'h01,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,1,1,0,0,0, 8'h01,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,0,1,0,0,0, 8'h02,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,1,1,0,0,0, 8'h02,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,0,1,0,0,0, 8'h03,8'h00,0,0));
    // int_n low blocks the edge
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,0,1,1,0,0,0, 8'h03,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,0,0,1,0,0,0, 8'h03,8'h00,0,0));
    // write on an edge tick wins
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,1,1,0,0,0, 8'h03,8'h00,0,0));
    vq.push_back(v(1,1,1,0,8'h40,1,1,1,1,0,1,0,0,0, 8'h40,8'h00,0,0));
    // pin falls without a tick, counted on the next tick
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,1,1,0,0,0, 8'h40,8'h00,0,0));
    vq.push_back(v(1,0,0,0,8'h00,1,1,1,1,0,1,0,0,0, 8'h40,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,1,1,1,0,1,0,0,0, 8'h41,8'h00,0,0));
    // split mode, TL stopped, TH run by tr_h
    vq.push_back(v(1,0,0,1,8'hFF,3,0,0,1,1,0,0,0,0, 8'h41,8'hFF,0,0));
    vq.push_back(v(1,1,0,0,8'h00,3,0,0,1,1,0,1,0,0,
                   8'h41, SPLIT ? 8'h00 : 8'hFF, 0, SPLIT));
    vq.push_back(v(1,0,0,0,8'h00,3,0,0,1,1,0,1,0,1,
                   8'h41, SPLIT ? 8'h00 : 8'hFF, 0, 0));
    // reset mid-count with tf set and TL = 55
    vq.push_back(v(1,0,1,1,8'hFF,1,0,0,1,1,0,0,0,0, 8'hFF,8'hFF,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,0,0,1,1,1,0,0,0, 8'h00,8'h00,1,0));
    vq.push_back(v(1,0,1,0,8'h55,1,0,0,1,1,1,0,0,0, 8'h55,8'h00,1,0));
    vq.push_back(v(0,1,1,1,8'hAA,1,0,0,1,1,1,0,0,0, 8'h00,8'h00,0,0));
    vq.push_back(v(1,1,0,0,8'h00,1,0,0,1,1,1,0,0,0, 8'h01,8'h00,0,0));

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i), 1'b1);

    // auto-reload over a full 100-tick period, set beats clear
    apply(v(1,0,1,1,8'h9C,2,0,0,1,1,0,0,1,0, 8'h9C,8'h9C,0,0),
          "m2_load", 1'b1);
    for (int i = 0; i < 99; i++)
      apply(v(1,1,0,0,8'h00,2,0,0,1,1,1,0,0,0, 0,0,0,0),
            "m2_run", 1'b0);
    apply(v(1,0,0,0,8'h00,2,0,0,1,1,1,0,0,0, 8'hFF,8'h9C,0,0),
          "m2_99", 1'b1);
    apply(v(1,1,0,0,8'h00,2,0,0,1,1,1,0,1,0, 8'h9C,8'h9C,1,0),
          "m2_setclr", 1'b1);
    // TL write beats reload, no flag from the suppressed wrap
    apply(v(1,0,1,0,8'hFF,2,0,0,1,1,0,0,1,0, 8'hFF,8'h9C,0,0),
          "m2_pre", 1'b1);
    apply(v(1,1,1,0,8'h05,2,0,0,1,1,1,0,0,0, 8'h05,8'h9C,0,0),
          "m2_wrwin", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Parametrised 8051-style timer/counter holding a TL/TH register pair, an overflow flag and run control in one block, for use as Timer 0 or Timer 1. It sits beside the SFR file. The CPU writes TL/TH through byte strobes, and the control unit supplies TMOD/TCON fields plus a machine-cycle tick. It counts either ticks or falling edges on an external pin, in four modes: 13-bit, 16-bit, 8-bit auto-reload and split.

## Interface
- BYTE_W, 8: width of each of TL and TH.
- PRESC_W, 5: active low bits of TL in mode 0. Legal range 1..BYTE_W.

- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  one clock; reset is synchronous and active-low.
- i_tick  in  1  machine-cycle enable, one cycle wide; all counting qualified by it.
- i_byte  in  BYTE_W  write data.
- i_wr_tl  in  1  load TL from i_byte.
- i_wr_th  in  1  load TH from i_byte.
- i_mode  in  2  00 = 13-bit, 01 = 16-bit, 10 = 8-bit auto-reload, 11 = split.
- i_ct  in  1  0 = count ticks, 1 = count i_t_pin falling edges.
- i_gate  in  1  1 = also require i_int_n high to run.
- i_int_n  in  1  external gate pin.
- i_t_pin  in  1  external count pin.
- i_tr  in  1  run bit for the main counter.
- i_tr_h  in  1  run bit for TH in split mode.
- i_tf_clr  in  1  clear o_tf.
- i_tfh_clr  in  1  clear o_tf_h.
- o_tl  out  BYTE_W  TL register.
- o_th  out  BYTE_W  TH register.
- o_tf  out  1  main overflow flag.
- o_tf_h  out  1  TH overflow flag, split mode only.

## Operation
- Run condition: run = i_tr & (~i_gate | i_int_n).
- Count event, timer mode (i_ct = 0): i_tick & run.
- Count event, counter mode (i_ct = 1): i_tick & run & edge.
  - Pin sample register updates on every i_tick.
  - edge = (previous sample == 1) & (i_t_pin == 0) on that tick.
- Mode 00:
  - TL[PRESC_W-1:0] increments per event; upper TL bits are held.
  - When the low field wraps from all-ones to 0, TH increments.
  - TH wrapping from all-ones to 0 sets o_tf.
- Mode 01: {TH,TL} forms one 2·BYTE_W counter. Wrap from all-ones to 0 sets o_tf.
- Mode 10:
  - TL increments per event.
  - On TL wrap, TL loads TH instead of 0, and o_tf sets. TH is unchanged.
- Mode 11 (split):
  - TL uses the run condition and i_ct above; its wrap sets o_tf.
  - TH counts i_tick only when i_tr_h = 1, ignoring i_ct and i_gate; its wrap sets o_tf_h.
- Priority within one cycle, per register: i_wr_tl / i_wr_th beats increment or reload on that register.
  - In mode 01, a write to either half suppresses the whole 16-bit increment that cycle; the other half holds.
- Flags: a set beats a clear in the same cycle. Flags are otherwise sticky until cleared.
- Changing i_mode mid-count leaves TL/TH values intact; the new mode applies from the next event.
- Reset (i_rst_n = 0 at an edge): o_tl = 0, o_th = 0, o_tf = 0, o_tf_h = 0, pin sample = 1. Reset overrides all writes and events.

## Timing
- Write strobe at edge N: new value is visible on o_tl/o_th after edge N.
- Count event sampled at edge N: incremented value and flag set are visible after edge N, with zero extra latency.
- Counter mode: a pin high→low transition between tick k and tick k+1 counts at tick k+1.
  - The pin must be stable for at least one tick on each level; shorter pulses may be missed.
- Auto-reload: TL holds TH's value from the same cycle the wrap occurs. No all-zero TL state is visible.
- Deasserting i_tr (or i_int_n with i_gate = 1) stops counting at the next edge. Values are held.
- Reset mid-count: all state is zero after the reset edge. Counting resumes on the first event after i_rst_n returns high.

## Configuration
- TIMER_SPLIT_MODE_EN defined: mode 11 operates as split mode above.
- TIMER_SPLIT_MODE_EN undefined:
  - Mode 11 holds TL and TH (no counting, no flag sets); writes and clears still work. This matches the 8051 Timer 1 behaviour.
  - o_tf_h is tied to 0, and i_tr_h and i_tfh_clr are ignored.

## Test plan
- Mode 01, timer, i_tr = 1: write TL = 8'hFE, TH = 8'hFF; 2 ticks → o_th = 00, o_tl = 00, o_tf = 1. Next tick → o_tl = 01.
- Mode 00: TL = 8'hFF, TH = 8'h00; 1 tick → o_tl = 8'hE0, o_th = 8'h01, o_tf = 0. Also preload TH = 8'hFF, TL = 8'h1F; 1 tick → o_tf = 1.
- Mode 10: TH = 8'h9C, TL = 8'hFF; 1 tick → o_tl = 8'h9C, o_tf = 1. After 100 further ticks → o_tf set again; assert i_tf_clr with that overflow → o_tf = 1.
- Counter mode, i_gate = 1: pin toggles 1→0 three times with i_int_n = 1 → TL = 3. Repeat with i_int_n = 0 → TL unchanged. Write TL on the same tick as an edge → written value kept.
- Mode 11 with TIMER_SPLIT_MODE_EN, i_tr = 0, i_tr_h = 1: TH = 8'hFF; 1 tick → o_th = 0, o_tf_h = 1, o_tl unchanged. Without the macro → TH holds 8'hFF and o_tf_h = 0.
- Reset mid-count in mode 01 with TL = 8'h55 and o_tf = 1: i_rst_n low for 1 edge → all outputs 0. Ticks during reset are ignored.
